store_buffer: RTL and testbench

Posted-write buffer between the single-cycle MIPS core's data port (memwrite / dataadr / writedata) and a slower data memory with a req/ack handshake. Stores retire from the core in one cycle into a small FIFO and drain to memory in order; loads see buffered data via address forwarding. Stalls the core only when the FIFO is full (or, without forwarding, when a load would read stale memory).

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/store_buffer_fifo.sv | 95 +++++++++
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing helpers for the store buffer.
// Build option STORE_BUFFER_FWD_EN (see store_buffer.sv) does not affect this package.
package store_buffer_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } drain_state_e;

    // Bits [WORD_LSB-1:0] of a byte address are ignored for load/store matching.
    localparam int WORD_LSB = 2;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Ring storage for buffered stores: pointers, occupancy, head read port.
// With STORE_BUFFER_FWD_EN defined it also exports every entry for forwarding.
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push_i,
    input  logic                              pop_i,
    input  logic [AW-1:0]                     adr_i,
    input  logic [DW-1:0]                     data_i,
    output logic [AW-1:0]                     head_adr_o,
    output logic [DW-1:0]                     head_data_o,
`ifdef STORE_BUFFER_FWD_EN
    output logic [DEPTH-1:0][AW-1:0]          ent_adr_o,
    output logic [DEPTH-1:0][DW-1:0]          ent_data_o,
    output logic [DEPTH-1:0]                  ent_vld_o,
    output logic [ptr_width(DEPTH)-1:0]       rd_ptr_o,
`endif
    output logic [cnt_width(DEPTH)-1:0]       count_o,
    output logic                              full_o,
    output logic                              empty_o
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [DEPTH-1:0][AW-1:0] adr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload is only meaningful under the valid window, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            adr_q[wr_ptr_q]  <= adr_i;
            data_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_adr_o  = adr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] age;

    assign ent_adr_o  = adr_q;
    assign ent_data_o = data_q;
    assign rd_ptr_o   = rd_ptr_q;

    always_comb begin
        ent_vld_o = '0;
        age       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age          = PW'(i) - rd_ptr_q;
            ent_vld_o[i] = (CW'(age) < count_q);
        end
    end
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and a req/ack data memory.
// Define STORE_BUFFER_FWD_EN for load forwarding; otherwise loads stall until the buffer drains.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_memwrite,
    input  logic                        cpu_memread,
    input  logic [AW-1:0]               cpu_adr,
    input  logic [DW-1:0]               cpu_wdata,
    output logic                        cpu_stall,
    output logic                        cpu_rd_hit,
    output logic [DW-1:0]               cpu_rd_data,
    output logic                        mem_req,
    output logic [AW-1:0]               mem_adr,
    output logic [DW-1:0]               mem_wdata,
    input  logic                        mem_ack,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        empty
);

    localparam int PW = ptr_width(DEPTH);

    drain_state_e  state_q, state_d;
    logic [AW-1:0] mem_adr_q, mem_adr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          pop;
    logic          full;
    logic [AW-1:0] head_adr;
    logic [DW-1:0] head_data;

`ifdef STORE_BUFFER_FWD_EN
    logic [DEPTH-1:0][AW-1:0] ent_adr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [DEPTH-1:0]         ent_vld;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            idx;
`endif

    store_buffer_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (cpu_memwrite && !full),
        .pop_i       (pop),
        .adr_i       (cpu_adr),
        .data_i      (cpu_wdata),
        .head_adr_o  (head_adr),
        .head_data_o (head_data),
`ifdef STORE_BUFFER_FWD_EN
        .ent_adr_o   (ent_adr),
        .ent_data_o  (ent_data),
        .ent_vld_o   (ent_vld),
        .rd_ptr_o    (rd_ptr),
`endif
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        state_d     = state_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d     = S_BUSY;
                    mem_adr_d   = head_adr;
                    mem_wdata_d = head_data;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = (state_q == S_BUSY);
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef STORE_BUFFER_FWD_EN
    assign cpu_stall = cpu_memwrite && full;

    // Scan oldest to youngest so the youngest matching store overwrites earlier hits.
    always_comb begin
        cpu_rd_hit  = 1'b0;
        cpu_rd_data = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (cpu_memread && ent_vld[idx] &&
                (ent_adr[idx][AW-1:WORD_LSB] == cpu_adr[AW-1:WORD_LSB])) begin
                cpu_rd_hit  = 1'b1;
                cpu_rd_data = ent_data[idx];
            end
        end
    end
`else
    assign cpu_stall   = (cpu_memwrite && full) || (cpu_memread && !empty);
    assign cpu_rd_hit  = 1'b0;
    assign cpu_rd_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_memwrite, cpu_memread, mem_ack;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall, cpu_rd_hit, mem_req, empty;
    logic [DW-1:0] cpu_rd_data, mem_wdata;
    logic [AW-1:0] mem_adr;
    logic [CW-1:0] count;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_memwrite (cpu_memwrite),
        .cpu_memread  (cpu_memread),
        .cpu_adr      (cpu_adr),
        .cpu_wdata    (cpu_wdata),
        .cpu_stall    (cpu_stall),
        .cpu_rd_hit   (cpu_rd_hit),
        .cpu_rd_data  (cpu_rd_data),
        .mem_req      (mem_req),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .count        (count),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t mq[$];     // reference buffer contents, oldest first
    wr_t exp_q[$];  // writes the memory side must see, in order
    bit  req_m;     // reference: a write is currently presented to memory
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Memory-side monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && mem_req && mem_ack) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_write", 64'(mem_adr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("mon_adr", 64'(mem_adr), 64'(e.a));
                chk("mon_data", 64'(mem_wdata), 64'(e.d));
            end
        end
    end

    // Called at posedge+1; drives one cycle, checks, advances the model across the edge.
    task automatic cycle(input logic we, input logic re, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic ack);
        bit            hit_e, stall_e, acc, pop, nreq;
        logic [DW-1:0] rd_e;
        wr_t           e;
        cpu_memwrite = we;
        cpu_memread  = re;
        cpu_adr      = a;
        cpu_wdata    = d;
        mem_ack      = ack;
        #2;
        chk("count", 64'(count), 64'(mq.size()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        stall_e = (we && mq.size() == DEPTH) || (!FWD && re && mq.size() != 0);
        chk("stall", 64'(cpu_stall), 64'(stall_e));
        chk("mem_req", 64'(mem_req), 64'(req_m));
        if (req_m) begin
            chk("mem_adr", 64'(mem_adr), 64'(mq[0].a));
            chk("mem_wdata", 64'(mem_wdata), 64'(mq[0].d));
        end
        hit_e = 1'b0;
        rd_e  = '0;
        if (FWD && re) begin
            foreach (mq[i]) begin
                if (mq[i].a[AW-1:2] == a[AW-1:2]) begin
                    hit_e = 1'b1;
                    rd_e  = mq[i].d;
                end
            end
        end
        chk("rd_hit", 64'(cpu_rd_hit), 64'(hit_e));
        chk("rd_data", 64'(cpu_rd_data), 64'(rd_e));
        acc  = we && (mq.size() < DEPTH);
        pop  = req_m && ack;
        nreq = req_m ? !ack : (mq.size() != 0);
        e.a  = a;
        e.d  = d;
        if (acc) exp_q.push_back(e);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(e);
        req_m = nreq;
        #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((mq.size() != 0 || req_m) && n < 40) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1);
            n++;
        end
        chk(nm, 64'(mq.size() != 0 || req_m), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        reset        = 1'b1;
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b0;
        cpu_adr      = '0;
        cpu_wdata    = '0;
        mem_ack      = 1'b0;
        req_m        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_adr", 64'(mem_adr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_hit", 64'(cpu_rd_hit), 64'd0);
        chk("rst_rdata", 64'(cpu_rd_data), 64'd0);
        reset = 1'b0;

        // Single store with memory always ready.
        cycle(1'b1, 1'b0, 32'h54, 32'd7, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, '0, '0, 1'b1);

        // Fill with memory blocked; fifth store stalls, is rejected alongside an ack, then retried.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'(i + 1), 1'b0);
        cycle(1'b1, 1'b0, 32'h110, 32'd5, 1'b1);
        cycle(1'b1, 1'b0, 32'h110, 32'd5, 1'b0);
        chk("full_retry_count", 64'(count), 64'(DEPTH));
        drain("drain_full");

        // Same-word stores then loads: youngest match, ignored byte bits, miss.
        cycle(1'b1, 1'b0, 32'h50, 32'd1, 1'b0);
        cycle(1'b1, 1'b0, 32'h50, 32'd2, 1'b0);
        cycle(1'b0, 1'b1, 32'h50, '0, 1'b0);
        cycle(1'b0, 1'b1, 32'h52, '0, 1'b0);
        cycle(1'b0, 1'b1, 32'h60, '0, 1'b0);
        repeat (8) cycle(1'b0, 1'b1, 32'h50, '0, 1'b1);
        drain("drain_fwd");

        // Randomized traffic over a small address window.
        for (int i = 0; i < 500; i++) begin
            ra = (32'($urandom_range(20, 27)) << 2) | 32'($urandom_range(0, 3));
            cycle(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3), ra, $urandom,
                  ($urandom_range(0, 9) < (i < 250 ? 5 : 2)));
        end
        drain("drain_rand");
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while a write is in flight with three entries buffered.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'(9 + i), 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        chk("pre_rst_req", 64'(mem_req), 64'd1);
        chk("pre_rst_count", 64'(count), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_adr", 64'(mem_adr), 64'd0);
        chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
        mq.delete();
        exp_q.delete();
        req_m = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) cycle(1'b0, 1'b0, '0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
